pwm_multi_ch: RTL

- Parametrised multi-channel PWM generator; next generation of the single-channel PWM control unit/counter pair.
- Counter, control FSM and per-channel compare live in one block.
- One shared period counter drives N channels, each with its own duty and polarity.
- Adds double-buffered (shadow) config registers applied on period boundaries, graceful stop, and a defined idle level instead of a tri-stated output.
- Sits between the register/config front end and the output pins.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_cmp_ch.sv | 65 ++++++
 rtl/pwm_multi_ch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared constants for the multi-channel PWM generator.
//                Holds the control state encoding and the config address
//                map.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Control state encoding; the values are fixed so that existing
    // register dumps from the single-channel unit decode the same way.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // Config address of the TOP (period - 1) register.
    // Channel k's duty register sits at address k+1.
    localparam int ADDR_TOP = 0;

endpackage
`default_nettype wire

// File: rtl/pwm_cmp_ch.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_cmp_ch
//  Description : One PWM channel. Keeps a shadow and an active duty
//                register, compares the shared counter against the active
//                duty and registers the polarity-adjusted output.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_cmp_ch
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] cnt,
    input  logic             run,
    input  logic             pol,
    output logic             out
);

    logic [WIDTH-1:0] r_dutyShadow;
    logic [WIDTH-1:0] r_dutyAct;
    logic [WIDTH-1:0] w_dutyNext;
    logic             w_raw;

    // A write landing on a load point goes straight into the active copy.
    assign w_dutyNext = wr ? wdata : r_dutyShadow;

    // Duty above TOP keeps this true for the whole period (100 %),
    // duty of zero never lets it become true (0 %).
    assign w_raw = (cnt < r_dutyAct);

    // Shadow duty register, written from the config port in any state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dutyShadow <= '0;
        end else if (wr) begin
            r_dutyShadow <= wdata;
        end
    end

    // Active duty register, refreshed only at a load point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dutyAct <= '0;
        end else if (load) begin
            r_dutyAct <= w_dutyNext;
        end
    end

    // Registered output: compare result while running, inactive level otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= 1'b0;
        end else begin
            out <= run ? (w_raw ^ pol) : pol;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_multi_ch.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi_ch
//  Description : Multi-channel PWM generator. One shared period counter and
//                control FSM (IDLE/RUN/DRAIN) drive N_CH compare channels.
//                TOP and duty values are double-buffered and take effect at
//                start or on a counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N_CH   = 4,
    parameter int ADDR_W = $clog2(N_CH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              stop_at_end,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]  cfg_wdata,
    input  logic [N_CH-1:0]   pol,
    output logic [N_CH-1:0]   pwm_out,
    output logic              period_done,
    output logic              busy
);

    logic [1:0]       r_state;
    logic [1:0]       w_stateNext;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cntNext;
    logic [WIDTH-1:0] r_topShadow;
    logic [WIDTH-1:0] r_topAct;
    logic [WIDTH-1:0] w_topNext;
    logic             r_busy;
    logic             w_wrTop;
    logic             w_load;
    logic             w_wrap;
    logic             w_active;

    assign w_wrTop   = cfg_we && (cfg_addr == ADDR_W'(ADDR_TOP));
    assign w_topNext = w_wrTop ? cfg_wdata : r_topShadow;
    assign w_active  = (r_state == RUN) || (r_state == DRAIN);
    assign w_wrap    = (r_cnt == r_topAct);

    // The pulse marks the last cycle of a period, so it is decoded from
    // the current count rather than registered.
    assign period_done = w_active && w_wrap;
    assign busy        = r_busy;

    // Next state, next count and load point; stop beats stop_at_end beats start.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cntNext = '0;
                if (start && !stop) begin
                    w_load      = 1'b1;
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else if (w_wrap) begin
                    w_cntNext = '0;
                    // A drain request on the final cycle has nothing left
                    // to finish, so leave without reloading.
                    if (stop_at_end) begin
                        w_stateNext = IDLE;
                    end else begin
                        w_load = 1'b1;
                    end
                end else begin
                    w_cntNext = r_cnt + WIDTH'(1);
                    if (stop_at_end) begin
                        w_stateNext = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (stop || w_wrap) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + WIDTH'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // State, counter and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_busy  <= (w_stateNext != IDLE);
        end
    end

    // TOP shadow and active registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_topShadow <= '0;
            r_topAct    <= '0;
        end else begin
            if (w_wrTop) begin
                r_topShadow <= cfg_wdata;
            end
            if (w_load) begin
                r_topAct <= w_topNext;
            end
        end
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            localparam logic [ADDR_W-1:0] c_addr = ADDR_W'(i + 1);
            logic w_chWr;

            assign w_chWr = cfg_we && (cfg_addr == c_addr);

            pwm_cmp_ch #(
                .WIDTH (WIDTH)
            ) u_ch (
                .clk   (clk),
                .reset (reset),
                .load  (w_load),
                .wr    (w_chWr),
                .wdata (cfg_wdata),
                .cnt   (r_cnt),
                .run   (w_active),
                .pol   (pol[i]),
                .out   (pwm_out[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
